// File: rtl/mem_wb_stage.sv
// Writeback stage of the RV32I core: holds one retiring instruction, aligns load data,
// and drives the register-file write port. Optional retired-instruction counter under WB_INSTRET_EN.
module mem_wb_stage #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic [WIDTH-1:0]  in_alu_result,
    input  logic [WIDTH-1:0]  in_load_data,
    input  logic [WIDTH-1:0]  in_pc_plus4,
    input  logic              flush,
    input  logic              wb_stall,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [WIDTH-1:0]  rf_wdata,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [WIDTH-1:0]  fwd_data,
    output logic              retire
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]       instret
`endif
);

    // Byte/half lane extraction from an aligned RV32 word; unknown load types fall back to LW.
    function automatic logic [WIDTH-1:0] extract_load(
        input logic [2:0]       funct3,
        input logic [1:0]       addr_lo,
        input logic [WIDTH-1:0] word
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        case (addr_lo)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  extract_load = {{(WIDTH-8){byte_v[7]}}, byte_v};
            3'b001:  extract_load = {{(WIDTH-16){half_v[15]}}, half_v};
            3'b100:  extract_load = {{(WIDTH-8){1'b0}}, byte_v};
            3'b101:  extract_load = {{(WIDTH-16){1'b0}}, half_v};
            default: extract_load = word;
        endcase
    endfunction

    logic              valid_r;
    logic [ADDR_W-1:0] rd_r;
    logic              we_r;
    logic [WIDTH-1:0]  data_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              commit_s;
    logic              rd_nz_s;
    logic              we_next_s;
    logic [WIDTH-1:0]  wb_data_s;

    // Handshake: the slot is free when empty or when the held entry drains this cycle.
    always_comb begin
        in_ready_s = !valid_r || !wb_stall;
        accept_s   = in_valid && in_ready_s && !flush;
        commit_s   = valid_r && !wb_stall && !flush;
        rd_nz_s    = (rd_r != {ADDR_W{1'b0}});
    end

    // Writeback value is resolved at acceptance so the held entry is ready to write.
    always_comb begin
        we_next_s = in_reg_write && (in_wb_sel != 2'b11);
        case (in_wb_sel)
            2'b00:   wb_data_s = in_alu_result;
            2'b01:   wb_data_s = extract_load(in_funct3, in_addr_lo, in_load_data);
            2'b10:   wb_data_s = in_pc_plus4;
            default: wb_data_s = {WIDTH{1'b0}};
        endcase
    end

    // Single-entry holding register; flush wins over both accept and commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            rd_r    <= {ADDR_W{1'b0}};
            we_r    <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
            rd_r    <= in_rd;
            we_r    <= we_next_s;
            data_r  <= wb_data_s;
        end else if (commit_s) begin
            valid_r <= 1'b0;
        end
    end

    assign in_ready        = in_ready_s;
    assign retire          = commit_s;
    assign rf_write_enable = commit_s && we_r && rd_nz_s;
    assign rf_waddr        = rd_r;
    assign rf_wdata        = data_r;
    // Forwarding stays visible while stalled: the value is final even if the port is busy.
    assign fwd_valid       = valid_r && we_r && rd_nz_s;
    assign fwd_rd          = rd_r;
    assign fwd_data        = data_r;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_r;

    // Retired-instruction counter; wraps naturally at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= 64'd0;
        end else if (commit_s) begin
            instret_r <= instret_r + 64'd1;
        end
    end

    assign instret = instret_r;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed steps with a scoreboard of expected writes.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result;
    logic [31:0] in_load_data;
    logic [31:0] in_pc_plus4;
    logic        flush;
    logic        wb_stall;
    logic        rf_write_enable;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        retire;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   retire_cnt = 0;

    mem_wb_stage #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .in_alu_result(in_alu_result), .in_load_data(in_load_data), .in_pc_plus4(in_pc_plus4),
        .flush(flush), .wb_stall(wb_stall),
        .rf_write_enable(rf_write_enable), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retire(retire)
`ifdef WB_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_reg_write  = 1'b0;
        in_rd         = 5'd0;
        in_wb_sel     = 2'b00;
        in_funct3     = 3'b010;
        in_addr_lo    = 2'd0;
        in_alu_result = 32'd0;
        in_load_data  = 32'd0;
        in_pc_plus4   = 32'd0;
    endtask

    // Drive one instruction and record the write it must eventually produce.
    task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [31:0] pc4,
                        input logic exp_wen, input logic [31:0] exp_data);
        exp_t e;
        in_valid      = 1'b1;
        in_reg_write  = rw;
        in_rd         = rd;
        in_wb_sel     = sel;
        in_funct3     = f3;
        in_addr_lo    = lo;
        in_alu_result = alu;
        in_load_data  = ld;
        in_pc_plus4   = pc4;
        e.wen  = exp_wen;
        e.rd   = rd;
        e.data = exp_data;
        sb.push_back(e);
    endtask

    // Observe mid-cycle; any retire pulse is matched against the oldest expected write.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (retire === 1'b1) begin
            retire_cnt++;
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_en", 64'(rf_write_enable), 64'(e.wen));
                chk("wr_addr", 64'(rf_waddr), 64'(e.rd));
                chk("wr_data", 64'(rf_wdata), 64'(e.data));
                chk("fwd_data", 64'(fwd_data), 64'(e.data));
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] LD_WORD = 32'h80FF_7F01;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        wb_stall = 1'b0;
        idle();
        adv();
        sample();
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_we", 64'(rf_write_enable), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_fwd", 64'({fwd_valid, fwd_rd, fwd_data}), 64'd0);
        chk("rst_retire", 64'(retire), 64'd0);
        adv();
        rst = 1'b0;

        // ALU result, one-cycle latency
        send(1'b1, 5'd5, 2'b00, 3'b000, 2'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b1, 32'h1234_5678);
        sample();
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        adv();
        idle();
        sample();
        chk("alu_retire", 64'(retire), 64'd1);
        chk("alu_we", 64'(rf_write_enable), 64'd1);
        adv();

        // Load extraction, back-to-back
        send(1'b1, 5'd10, 2'b01, 3'b000, 2'd3, 32'd0, LD_WORD, 32'd0, 1'b1, 32'hFFFF_FF80);
        sample(); adv();
        send(1'b1, 5'd11, 2'b01, 3'b100, 2'd3, 32'd0, LD_WORD, 32'd0, 1'b1, 32'h0000_0080);
        sample(); adv();
        send(1'b1, 5'd12, 2'b01, 3'b001, 2'd2, 32'd0, LD_WORD, 32'd0, 1'b1, 32'hFFFF_80FF);
        sample(); adv();
        send(1'b1, 5'd13, 2'b01, 3'b101, 2'd0, 32'd0, LD_WORD, 32'd0, 1'b1, 32'h0000_7F01);
        sample(); adv();
        send(1'b1, 5'd14, 2'b01, 3'b011, 2'd1, 32'd0, LD_WORD, 32'd0, 1'b1, LD_WORD);
        sample(); adv();
        send(1'b1, 5'd15, 2'b01, 3'b001, 2'd0, 32'd0, LD_WORD, 32'd0, 1'b1, 32'h0000_7F01);
        sample(); adv();
        // wb_sel=11: no write, still retires
        send(1'b1, 5'd3, 2'b11, 3'b000, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 32'd0);
        sample(); adv();
        idle();
        sample();
        chk("none_fwd", 64'(fwd_valid), 64'd0);
        adv();
        sample();
        chk("drained_retire", 64'(retire), 64'd0);
        adv();

        // Stall holds the entry for three cycles
        send(1'b1, 5'd7, 2'b00, 3'b000, 2'd0, 32'hCAFE_0007, 32'd0, 32'd0, 1'b1, 32'hCAFE_0007);
        sample(); adv();
        idle();
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("stall_ready", 64'(in_ready), 64'd0);
            chk("stall_fwd", 64'({fwd_valid, fwd_rd}), 64'({1'b1, 5'd7}));
            chk("stall_we", 64'(rf_write_enable), 64'd0);
            chk("stall_retire", 64'(retire), 64'd0);
            adv();
        end
        wb_stall = 1'b0;
        sample();
        chk("release_retire", 64'(retire), 64'd1);
        adv();
        sample();
        chk("release_once", 64'(retire), 64'd0);
        adv();

        // rd=0 link write is suppressed but retires
        send(1'b1, 5'd0, 2'b10, 3'b000, 2'd0, 32'd0, 32'd0, 32'h0000_0104, 1'b0, 32'h0000_0104);
        sample(); adv();
        idle();
        sample();
        chk("rd0_fwd", 64'(fwd_valid), 64'd0);
        chk("rd0_retire", 64'(retire), 64'd1);
        adv();

        // Flush beats stall and discards the incoming instruction
        send(1'b1, 5'd9, 2'b00, 3'b000, 2'd0, 32'h0000_0099, 32'd0, 32'd0, 1'b1, 32'h0000_0099);
        sample(); adv();
        in_rd = 5'd12;
        in_alu_result = 32'h0000_0055;
        wb_stall = 1'b1;
        flush = 1'b1;
        sample();
        chk("flush_we", 64'(rf_write_enable), 64'd0);
        chk("flush_retire", 64'(retire), 64'd0);
        adv();
        flush = 1'b0;
        wb_stall = 1'b0;
        idle();
        sample();
        chk("flush_empty_fwd", 64'(fwd_valid), 64'd0);
        chk("flush_empty_retire", 64'(retire), 64'd0);
        chk("flush_empty_ready", 64'(in_ready), 64'd1);
        chk("flush_sb", 64'(sb.size()), 64'd1);
        sb.delete();
        adv();

`ifdef WB_INSTRET_EN
        chk("instret_total", instret, 64'(retire_cnt));
        rst = 1'b1;
        #1;
        chk("instret_rst", instret, 64'd0);
        adv();
        rst = 1'b0;
`endif

        // Four back-to-back accepts give four consecutive retires
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 5'(20 + i), 2'b00, 3'b000, 2'd0, 32'(32'hA000 + i), 32'd0, 32'd0,
                 1'b1, 32'(32'hA000 + i));
            sample();
            chk("b2b_ready", 64'(in_ready), 64'd1);
            if (i > 0) chk("b2b_retire", 64'(retire), 64'd1);
            adv();
        end
        idle();
        sample();
        chk("b2b_last_retire", 64'(retire), 64'd1);
        adv();
        sample();
        chk("b2b_done", 64'(retire), 64'd0);
`ifdef WB_INSTRET_EN
        chk("instret_4", instret, 64'd4);
`endif
        adv();

        // Asynchronous reset with an entry held
        send(1'b1, 5'd6, 2'b00, 3'b000, 2'd0, 32'h0000_0066, 32'd0, 32'd0, 1'b1, 32'h0000_0066);
        adv();
        idle();
        wb_stall = 1'b1;
        #1;
        chk("held_fwd", 64'(fwd_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_fwd", 64'(fwd_valid), 64'd0);
        chk("async_we", 64'(rf_write_enable), 64'd0);
        chk("async_ready", 64'(in_ready), 64'd1);
`ifdef WB_INSTRET_EN
        chk("async_instret", instret, 64'd0);
`endif
        sb.delete();
        wb_stall = 1'b0;
        adv();
        rst = 1'b0;
        sample();
        chk("after_rst_retire", 64'(retire), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
